uart_wb_tx_core: RTL and testbench
==================================

Name: uart_wb_tx_core

Overview:
Parametrised Wishbone-slave UART transmit engine with a programmable baud divisor, a configurable-depth TX FIFO, and 5–8-bit frames with optional parity and 1/2 stop bits. It is the transmit half of the next-generation UART and exposes the same Wishbone and pad signal set as the existing 16550-compatible core. It is the DUT for the TX-path agents of the UVM environment.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, range 2..256
DIV_W, 16, baud divisor width in bits (DLL/DLM hold 2 bytes, upper bits zero when DIV_W<16)
OVS, 16, baud ticks per serial bit (oversample factor), ≥1

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
wb_addr_i  in  3  register select
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data, valid while wb_ack_o=1
wb_we_i  in  1  1=write, 0=read
wb_sel_i  in  4  byte select; only bit0 used, others ignored
wb_stb_i  in  1  transfer strobe
wb_cyc_i  in  1  bus cycle in progress
wb_ack_o  out  1  transfer acknowledge
stx_pad_o  out  1  serial output, idle high
baud_o  out  1  one-cycle baud tick (OVS per bit)
int_o  out  1  TX-empty interrupt, registered

Behaviour:
- Reset (synchronous, wb_rst_i=1 at posedge): stx_pad_o=1, wb_ack_o=0, wb_dat_o=0, baud_o=0, int_o=0. Registers: IER=0x00, LCR=0x03 (8N1), DLL=DLM=0x00. FIFO is emptied, overflow cleared, FSM=IDLE. Reset mid-frame aborts the frame; the line is high on the next cycle.
- Wishbone: wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o, so ack is a 1-cycle pulse, latency 1, and a held strobe gets ack every 2nd cycle. The write side effect and the read data both occur on the ack cycle. wb_sel_i[0]=0 gives ack but no write effect and reads 0x00.
- Register map (addr: write / read):
  - 0: THR push / reads 0x00.
  - 1: IER[1]=TX-empty interrupt enable / IER.
  - 2: FCR[1]=1 clears the FIFO; the in-flight frame is not aborted / reads 0x00.
  - 3: LCR. [1:0] word length 5+n; [2] 2 stop bits; [3] parity enable; [4] even parity; [5] stick parity (parity = ~LCR[4]); [6] break / reads LCR.
  - 4: DLL. 5: DLM.
  - 6: LSR read-only. [5] FIFO empty; [6] FIFO empty AND FSM=IDLE; [7] overflow (sticky, cleared by the LSR read's ack); others 0.
  - 7: scratch, read/write.
- FIFO: THR write when count=FIFO_DEPTH drops the data and sets LSR[7]. A push and a pop in the same cycle is legal; count is unchanged. An FCR clear in the same cycle as a THR push wins: the FIFO ends empty.
- Baud generator: divisor = {DLM,DLL}[DIV_W-1:0]. Divisor 0 halts the generator (baud_o=0, FSM frozen, line held). Otherwise a counter counts 1..divisor; baud_o pulses on reaching divisor, then the counter returns to 1. A write to DLL or DLM restarts the counter at 1.
- TX FSM, advancing only on baud ticks; each state lasts OVS ticks:
  - IDLE: stx=1. On a tick with the FIFO non-empty, pop the FIFO into the shifter, latch LCR[5:0] (mid-frame LCR changes take effect on the next frame), go to START.
  - START: stx=0, then DATA.
  - DATA: LSB first, 5+LCR[1:0] bits, then PARITY if enabled, else STOP.
  - PARITY: stx = XOR of data bits, inverted if odd parity selected; stick mode overrides. Then STOP.
  - STOP: stx=1 for 1 or 2 bit periods. Then IDLE; a non-empty FIFO starts the next frame with no gap beyond the IDLE→START tick.
- Break: LCR[6]=1 forces stx_pad_o=0 combinationally-registered (1-cycle latency) without disturbing FSM timing.
- int_o <= IER[1] & LSR[5].

Test Plan:
- Reset then read: addr3 → 0x03; addr6 → 0x60; stx_pad_o=1; int_o=0; every ack exactly 1 cycle after stb.
- DLL=0x01, LCR=0x03, THR=0xA5 → stx after the start tick: 0, then 1,0,1,0,0,1,0,1, then 1. Each bit is 16 clk. LSR[6] returns to 1 after the stop bit.
- LCR=0x1A (7-bit, even parity, 1 stop), THR=0x41 → data 1000001, parity bit 0, stop bit 1; frame = 10 bits × OVS ticks.
- FIFO_DEPTH=16 with divisor 0 (halted): 17 THR writes → LSR=0x80 (overflow set, FIFO non-empty); second LSR read → 0x00; FIFO count 16.
- IER=0x02, write 2 bytes at DLL=2 → int_o=0 while the FIFO is non-empty, and int_o=1 one cycle after the second pop. FCR=0x02 mid-frame: the current frame completes and later frames are dropped.
- Assert wb_rst_i mid-DATA → next cycle stx_pad_o=1, LSR=0x60, LCR=0x03, no residual frame after reset release.

Source files
------------

// File: rtl/uart_wb_tx_core_if.sv
// Wishbone register-bus bundle for the UART transmit core.
// Handshake: the master holds wb_stb_i/wb_cyc_i (plus addr/data/we/sel) until it sees
// wb_ack_o; the slave pulses wb_ack_o for exactly one cycle, and wb_dat_o is valid only then.
interface uart_wb_tx_core_if;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we_i;
    logic [3:0] wb_sel_i;
    logic       wb_stb_i;
    logic       wb_cyc_i;
    logic       wb_ack_o;

    modport slave (
        input  wb_addr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_addr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/uart_wb_tx_core.sv
// Wishbone-slave UART transmitter: register file, TX FIFO, baud divider and
// frame serialiser (5-8 data bits, optional parity, 1/2 stop bits, break).
module uart_wb_tx_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int OVS        = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    uart_wb_tx_core_if.slave       wb,
    output logic                   stx_pad_o,
    output logic                   baud_o,
    output logic                   int_o,
    output logic [2:0]             state_dbg
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    ier, lcr, dll, dlm, scr, rdata;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [DIV_W-1:0] bcnt, divisor;
    logic [15:0]   div_full;
    state_t        state;
    logic [OW-1:0] ovs_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter, head_mask;
    logic [5:0]    frame_lcr;
    logic          par_bit, par_calc, tx_bit;

    logic req, wr_en, rd_en, thr_wr, fcr_clr, div_wr;
    logic fifo_empty, fifo_full, push, pop;

    assign req        = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
    assign wr_en      = req & wb.wb_we_i & wb.wb_sel_i[0];
    assign rd_en      = req & ~wb.wb_we_i & wb.wb_sel_i[0];
    assign thr_wr     = wr_en && (wb.wb_addr_i == 3'd0);
    assign fcr_clr    = wr_en && (wb.wb_addr_i == 3'd2) && wb.wb_dat_i[1];
    assign div_wr     = wr_en && (wb.wb_addr_i == 3'd4 || wb.wb_addr_i == 3'd5);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL);
    assign push       = thr_wr && !fifo_full;
    assign pop        = baud_o && (state == IDLE) && !fifo_empty;
    assign div_full   = {dlm, dll};
    assign divisor    = div_full[DIV_W-1:0];
    assign state_dbg  = state;

    // Parity is computed from the frame's own LCR snapshot at pop time.
    assign head_mask = 8'hFF >> (2'd3 - lcr[1:0]);
    assign par_calc  = lcr[5] ? ~lcr[4] : ((^(mem[rd_ptr] & head_mask)) ^ ~lcr[4]);

    always_comb begin
        rdata = 8'h00;
        case (wb.wb_addr_i)
            3'd1: rdata = ier;
            3'd3: rdata = lcr;
            3'd4: rdata = dll;
            3'd5: rdata = dlm;
            3'd6: rdata = {overflow, fifo_empty && (state == IDLE), fifo_empty, 5'b0};
            3'd7: rdata = scr;
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shifter[0];
            PARITY:  tx_bit = par_bit;
            default: tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= 8'h00;
            ier <= 8'h00; lcr <= 8'h03; dll <= 8'h00; dlm <= 8'h00; scr <= 8'h00;
            int_o <= 1'b0;
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= rd_en ? rdata : 8'h00;
            int_o       <= ier[1] & fifo_empty;
            if (wr_en) begin
                case (wb.wb_addr_i)
                    3'd1: ier <= wb.wb_dat_i;
                    3'd3: lcr <= wb.wb_dat_i;
                    3'd4: dll <= wb.wb_dat_i;
                    3'd5: dlm <= wb.wb_dat_i;
                    3'd7: scr <= wb.wb_dat_i;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !fcr_clr) mem[wr_ptr] <= wb.wb_dat_i;
    end

    // A clear beats any same-cycle push or pop; overflow set beats the LSR-read clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
        end else begin
            if (rd_en && wb.wb_addr_i == 3'd6) overflow <= 1'b0;
            if (thr_wr && fifo_full)            overflow <= 1'b1;
            if (fcr_clr) begin
                wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || div_wr) begin
            bcnt <= DIV_W'(1); baud_o <= 1'b0;
        end else if (divisor == '0) begin
            baud_o <= 1'b0;
        end else if (bcnt >= divisor) begin
            bcnt <= DIV_W'(1); baud_o <= 1'b1;
        end else begin
            bcnt <= bcnt + 1'b1; baud_o <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE; ovs_cnt <= '0; bit_cnt <= 3'd0; shifter <= 8'h00;
            frame_lcr <= 6'h03; par_bit <= 1'b0; stx_pad_o <= 1'b1;
        end else begin
            stx_pad_o <= lcr[6] ? 1'b0 : tx_bit;
            if (baud_o) begin
                if (state == IDLE) begin
                    if (!fifo_empty) begin
                        shifter <= mem[rd_ptr]; frame_lcr <= lcr[5:0]; par_bit <= par_calc;
                        state <= START; ovs_cnt <= '0; bit_cnt <= 3'd0;
                    end
                end else if (ovs_cnt != OVS_LAST) begin
                    ovs_cnt <= ovs_cnt + 1'b1;
                end else begin
                    ovs_cnt <= '0;
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            shifter <= shifter >> 1;
                            if (bit_cnt == 3'd4 + {1'b0, frame_lcr[1:0]}) begin
                                bit_cnt <= 3'd0;
                                state   <= frame_lcr[3] ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        PARITY: state <= STOP;
                        STOP: begin
                            if (frame_lcr[2] && bit_cnt == 3'd0) bit_cnt <= 3'd1;
                            else begin
                                bit_cnt <= 3'd0; state <= IDLE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_wb_tx_core.sv
// Directed bench for uart_wb_tx_core: read-data scoreboard plus a serial-line
// monitor that samples each frame bit at its midpoint against queued expectations.
module tb_uart_wb_tx_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       stx, baud, intr;
    logic [2:0] state_dbg;

    uart_wb_tx_core_if bus();

    uart_wb_tx_core #(.FIFO_DEPTH(16), .DIV_W(16), .OVS(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
        .stx_pad_o(stx), .baud_o(baud), .int_o(intr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic       exp_bit_q[$];
    int         exp_len_q[$];
    int         bit_clks = 16;
    bit         quiet = 1'b0;
    bit         mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wb_cycle(input logic [2:0] a, input logic [7:0] d, input logic we,
                            input logic [3:0] sel);
        @(negedge clk);
        bus.wb_addr_i = a; bus.wb_dat_i = d; bus.wb_we_i = we; bus.wb_sel_i = sel;
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("ack_latency", bus.wb_ack_o, 1);
        for (int i = 0; i < 4 && !bus.wb_ack_o; i++) begin
            @(posedge clk); #1;
        end
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        wb_cycle(a, d, 1'b1, 4'h1);
    endtask

    task automatic wb_read(input logic [2:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        wb_cycle(a, 8'h00, 1'b0, 4'h1);
    endtask

    // Frame bits are given with bit 0 = start bit, sent first.
    task automatic expect_frame(input logic [15:0] bits, input int len);
        exp_len_q.push_back(len);
        for (int i = 0; i < len; i++) exp_bit_q.push_back(bits[i]);
    endtask

    task automatic wait_tx_done(input int max_cycles);
        int n = 0;
        while ((exp_len_q.size() != 0 || mon_busy) && n < max_cycles) begin
            @(posedge clk); n++;
        end
        tests++;
        if (n >= max_cycles) begin
            fails++;
            $display("FAIL tx_done_timeout: got %0d frames pending expected 0", exp_len_q.size());
        end
        repeat (bit_clks) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.wb_ack_o && !bus.wb_we_i) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", bus.wb_dat_o);
            end else begin
                check("rd_data", bus.wb_dat_o, exp_q.pop_front());
            end
        end
    end

    initial begin : ser_mon
        logic prev;
        int   len;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!quiet && prev && !stx) begin
                if (exp_len_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL ser_unexpected_frame: got start bit expected idle line");
                end else begin
                    len = exp_len_q.pop_front();
                    mon_busy = 1'b1;
                    repeat (bit_clks / 2 - 1) @(negedge clk);
                    for (int i = 0; i < len; i++) begin
                        if (i > 0) repeat (bit_clks) @(negedge clk);
                        check("ser_bit", stx, exp_bit_q.pop_front());
                    end
                    mon_busy = 1'b0;
                end
            end
            prev = stx;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ones;
        bit  seen_low;
        bus.wb_addr_i = 3'd0; bus.wb_dat_i = 8'h00; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = 4'h0; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stx", stx, 1);
        check("rst_int", intr, 0);
        check("rst_ack", bus.wb_ack_o, 0);
        check("rst_baud", baud, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        @(negedge clk); rst = 1'b0;

        wb_read(3'd3, 8'h03);
        wb_read(3'd6, 8'h60);
        wb_read(3'd1, 8'h00);
        wb_write(3'd7, 8'h5A);
        wb_read(3'd7, 8'h5A);
        wb_cycle(3'd7, 8'hFF, 1'b1, 4'hE);
        wb_read(3'd7, 8'h5A);
        exp_q.push_back(8'h00);
        wb_cycle(3'd7, 8'h00, 1'b0, 4'h0);

        // 8N1, divisor 1: 16 clocks per bit
        bit_clks = 16;
        wb_write(3'd4, 8'h01);
        expect_frame({1'b1, 8'hA5, 1'b0}, 10);
        wb_write(3'd0, 8'hA5);
        wb_read(3'd6, 8'h20);
        wait_tx_done(1000);
        wb_read(3'd6, 8'h60);

        // 7 bits, even parity: 0x41 has two ones -> parity 0
        wb_write(3'd3, 8'h1A);
        expect_frame({1'b1, 1'b0, 7'h41, 1'b0}, 10);
        wb_write(3'd0, 8'h41);
        wait_tx_done(1000);

        // 5 bits, odd parity, 2 stop: 0x13 -> 10011 has three ones -> parity 0
        wb_write(3'd3, 8'h0C);
        expect_frame({2'b11, 1'b0, 5'h13, 1'b0}, 9);
        wb_write(3'd0, 8'h13);
        wait_tx_done(1000);

        // 8 bits, stick parity with LCR[4]=0 -> parity forced 1
        wb_write(3'd3, 8'h2B);
        expect_frame({1'b1, 1'b1, 8'h00, 1'b0}, 11);
        wb_write(3'd0, 8'h00);
        wait_tx_done(1000);
        wb_read(3'd3, 8'h2B);

        // halted generator, overflow on the 17th push
        wb_write(3'd4, 8'h00);
        for (int i = 0; i < 17; i++) wb_write(3'd0, 8'(i));
        wb_read(3'd6, 8'h80);
        wb_read(3'd6, 8'h00);
        check("fifo_count_full", dut.count, 16);
        wb_write(3'd2, 8'h02);
        wb_read(3'd6, 8'h60);

        // interrupt on TX empty, divisor 2
        wb_write(3'd3, 8'h03);
        bit_clks = 32;
        wb_write(3'd1, 8'h02);
        @(posedge clk); #1;
        check("int_empty_idle", intr, 1);
        wb_read(3'd1, 8'h02);
        wb_write(3'd4, 8'h02);
        expect_frame({1'b1, 8'h3C, 1'b0}, 10);
        expect_frame({1'b1, 8'hC3, 1'b0}, 10);
        wb_write(3'd0, 8'h3C);
        wb_write(3'd0, 8'hC3);
        @(posedge clk); #1;
        check("int_fifo_busy", intr, 0);
        ones = 0;
        repeat (20) begin
            @(negedge clk); ones += int'(baud);
        end
        check("baud_rate_div2", ones, 10);
        repeat (230) @(posedge clk);
        #1;
        check("int_before_pop", intr, 0);
        repeat (200) @(posedge clk);
        #1;
        check("int_after_pop", intr, 1);
        wait_tx_done(2000);

        // FIFO clear mid-frame: current frame finishes, queued ones vanish
        expect_frame({1'b1, 8'h55, 1'b0}, 10);
        wb_write(3'd0, 8'h55);
        wb_write(3'd0, 8'h66);
        wb_write(3'd0, 8'h77);
        repeat (100) @(posedge clk);
        wb_write(3'd2, 8'h02);
        wait_tx_done(2000);
        repeat (700) @(posedge clk);
        wb_read(3'd6, 8'h60);

        // reset in the middle of the data bits
        bit_clks = 16;
        wb_write(3'd4, 8'h01);
        quiet = 1'b1;
        wb_write(3'd0, 8'h00);
        repeat (64) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_stx", stx, 1);
        @(negedge clk); rst = 1'b0;
        wb_read(3'd6, 8'h60);
        wb_read(3'd3, 8'h03);
        seen_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!stx) seen_low = 1'b1;
        end
        check("no_residual_frame", seen_low, 0);
        quiet = 1'b0;

        repeat (4) @(posedge clk);
        check("rd_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
